// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundle of the CPU port, the video port and the external SRAM pins
//   that surround the SRAM arbiter.
//   slave  modport : the arbiter side. It takes the requests, addresses,
//                    write data and SRAM read data, and drives the acks,
//                    read data and SRAM control pins.
//   master modport : the requester/board side, which is the mirror image.
//   Signals:
//     cpu_req/cpu_we/cpu_addr[20:0]/cpu_wdata[7:0] -> CPU request
//     cpu_ack/cpu_rdata[7:0]                       <- CPU completion
//     vid_req/vid_addr[20:0]                       -> video fetch request
//     vid_ack/vid_rdata[7:0]                       <- video completion
//     sram_addr[20:0]/sram_dout[7:0]/sram_oe/sram_we_n <- SRAM pins
//     sram_din[7:0]                                -> SRAM read data
interface sram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req;
  logic [20:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_oe;
  logic        sram_we_n;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_din,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    output sram_addr, sram_dout, sram_oe, sram_we_n
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_din,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    input  sram_addr, sram_dout, sram_oe, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one asynchronous 8-bit SRAM between a CPU port (read/write) and a
//   video port (read only). Each transaction runs IDLE -> SETUP ->
//   ACCESS (ACCESS_CYCLES cycles) -> HOLD -> IDLE. Address and write data
//   stay stable from SETUP through HOLD, which puts one cycle of setup and
//   one cycle of hold around the write strobe. Under contention the grants
//   alternate, starting with video after reset.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high reset; aborts any transaction
//     bus   : sram_arbiter_if.slave (CPU port, video port, SRAM pins)
//   All outputs come straight from registers.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic           clock,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // The counter value on the last strobe cycle.
  localparam logic [3:0] LP_LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_win_vid, w_win_vid_nxt;
  logic        r_write, w_write_nxt;
  logic        r_last_vid, w_last_vid_nxt;
  logic [20:0] r_sram_addr, w_sram_addr_nxt;
  logic [7:0]  r_sram_dout, w_sram_dout_nxt;
  logic        r_sram_oe, w_sram_oe_nxt;
  logic        r_sram_we_n, w_sram_we_n_nxt;
  logic        r_cpu_ack, w_cpu_ack_nxt;
  logic        r_vid_ack, w_vid_ack_nxt;
  logic [7:0]  r_cpu_rdata, w_cpu_rdata_nxt;
  logic [7:0]  r_vid_rdata, w_vid_rdata_nxt;

  // Video wins unless the CPU is also asking and video had the last grant.
  logic w_grant_vid, w_grant_cpu, w_grant;
  assign w_grant_vid = bus.vid_req & (~bus.cpu_req | ~r_last_vid);
  assign w_grant_cpu = bus.cpu_req & ~w_grant_vid;
  assign w_grant     = w_grant_vid | w_grant_cpu;

  // State register plus every registered output and datapath latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_win_vid   <= 1'b0;
      r_write     <= 1'b0;
      r_last_vid  <= 1'b0;
      r_sram_addr <= 21'd0;
      r_sram_dout <= 8'd0;
      r_sram_oe   <= 1'b0;
      r_sram_we_n <= 1'b1;
      r_cpu_ack   <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_vid_rdata <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_win_vid   <= w_win_vid_nxt;
      r_write     <= w_write_nxt;
      r_last_vid  <= w_last_vid_nxt;
      r_sram_addr <= w_sram_addr_nxt;
      r_sram_dout <= w_sram_dout_nxt;
      r_sram_oe   <= w_sram_oe_nxt;
      r_sram_we_n <= w_sram_we_n_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_vid_ack   <= w_vid_ack_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_vid_rdata <= w_vid_rdata_nxt;
    end
  end

  // Next-state logic and the strobe-length counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_SETUP;
        else         w_state_nxt = S_IDLE;
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_cnt == LP_LAST_CNT) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, the request latches and the grant history.
  always_comb begin
    w_win_vid_nxt   = r_win_vid;
    w_write_nxt     = r_write;
    w_last_vid_nxt  = r_last_vid;
    w_sram_addr_nxt = r_sram_addr;
    w_sram_dout_nxt = r_sram_dout;
    w_sram_oe_nxt   = r_sram_oe;
    w_sram_we_n_nxt = r_sram_we_n;
    w_cpu_ack_nxt   = 1'b0;
    w_vid_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_vid_rdata_nxt = r_vid_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_win_vid_nxt   = w_grant_vid;
          w_last_vid_nxt  = w_grant_vid;
          w_write_nxt     = w_grant_cpu & bus.cpu_we;
          w_sram_addr_nxt = w_grant_vid ? bus.vid_addr : bus.cpu_addr;
          w_sram_dout_nxt = w_grant_cpu ? bus.cpu_wdata : r_sram_dout;
          // For a write the data bus is driven from SETUP, so the data is settled before the strobe.
          w_sram_oe_nxt   = w_grant_cpu & bus.cpu_we;
        end else begin
          w_sram_oe_nxt   = 1'b0;
        end
      end
      S_SETUP: begin
        w_sram_we_n_nxt = ~r_write;
      end
      S_ACCESS: begin
        if (r_cnt == LP_LAST_CNT) begin
          w_sram_we_n_nxt = 1'b1;
          if (r_win_vid) w_vid_ack_nxt = 1'b1;
          else           w_cpu_ack_nxt = 1'b1;
          if (!r_write) begin
            if (r_win_vid) w_vid_rdata_nxt = bus.sram_din;
            else           w_cpu_rdata_nxt = bus.sram_din;
          end else begin
            w_cpu_rdata_nxt = r_cpu_rdata;
          end
        end else begin
          w_sram_we_n_nxt = ~r_write;
        end
      end
      S_HOLD: begin
        w_sram_oe_nxt   = 1'b0;
        w_sram_we_n_nxt = 1'b1;
      end
      default: begin
        w_sram_oe_nxt   = 1'b0;
        w_sram_we_n_nxt = 1'b1;
      end
    endcase
  end

  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.vid_ack   = r_vid_ack;
  assign bus.vid_rdata = r_vid_rdata;
  assign bus.sram_addr = r_sram_addr;
  assign bus.sram_dout = r_sram_dout;
  assign bus.sram_oe   = r_sram_oe;
  assign bus.sram_we_n = r_sram_we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with the default strobe
// length plus two instances with strobe lengths 1 and 15.
// The bench changes inputs and samples outputs on the falling edge.
module tb_sram_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sram_arbiter_if b2();
  sram_arbiter_if b1();
  sram_arbiter_if b15();

  sram_arbiter #(.ACCESS_CYCLES(2))  u_dut2  (.clock(clock), .reset(reset), .bus(b2.slave));
  sram_arbiter #(.ACCESS_CYCLES(1))  u_dut1  (.clock(clock), .reset(reset), .bus(b1.slave));
  sram_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (.clock(clock), .reset(reset), .bus(b15.slave));

  always #5 clock = ~clock;

  task automatic test_reset();
    b2.cpu_req = 1'b0; b2.cpu_we = 1'b0; b2.cpu_addr = 21'h0; b2.cpu_wdata = 8'h00;
    b2.vid_req = 1'b0; b2.vid_addr = 21'h0; b2.sram_din = 8'h00;
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = 21'h0; b1.cpu_wdata = 8'h00;
    b1.vid_req = 1'b0; b1.vid_addr = 21'h0; b1.sram_din = 8'h00;
    b15.cpu_req = 1'b0; b15.cpu_we = 1'b0; b15.cpu_addr = 21'h0; b15.cpu_wdata = 8'h00;
    b15.vid_req = 1'b0; b15.vid_addr = 21'h0; b15.sram_din = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({b2.sram_we_n, b2.sram_oe, b2.cpu_ack, b2.vid_ack, b2.sram_addr, b2.sram_dout, b2.cpu_rdata, b2.vid_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 21'h0, 8'h00, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_ac2 got we_n=%0b oe=%0b cack=%0b vack=%0b addr=%0h dout=%0h crd=%0h vrd=%0h exp 1 0 0 0 0 0 0 0",
               b2.sram_we_n, b2.sram_oe, b2.cpu_ack, b2.vid_ack, b2.sram_addr, b2.sram_dout, b2.cpu_rdata, b2.vid_rdata);
    end
    checks++;
    if ({b1.sram_we_n, b1.sram_oe, b1.cpu_ack, b1.sram_addr} !== {1'b1, 1'b0, 1'b0, 21'h0}) begin
      failures++;
      $display("FAIL reset_ac1 got we_n=%0b oe=%0b ack=%0b addr=%0h exp 1 0 0 0", b1.sram_we_n, b1.sram_oe, b1.cpu_ack, b1.sram_addr);
    end
    checks++;
    if ({b15.sram_we_n, b15.sram_oe, b15.cpu_ack, b15.sram_addr} !== {1'b1, 1'b0, 1'b0, 21'h0}) begin
      failures++;
      $display("FAIL reset_ac15 got we_n=%0b oe=%0b ack=%0b addr=%0h exp 1 0 0 0", b15.sram_we_n, b15.sram_oe, b15.cpu_ack, b15.sram_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    int c, first, acks, vacks, welow;
    b2.cpu_we = 1'b0; b2.cpu_addr = 21'h0F000; b2.sram_din = 8'hA5; b2.cpu_req = 1'b1;
    c = 1; first = 0; acks = 0; vacks = 0; welow = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      c++;
      if (b2.cpu_ack) begin
        acks++;
        if (first == 0) first = c;
        b2.cpu_req = 1'b0;
      end
      if (b2.vid_ack) vacks++;
      if (!b2.sram_we_n) welow++;
    end
    checks++;
    if (first != 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", first); end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL rd_ack_count got=%0d exp=1", acks); end
    checks++;
    if (welow != 0) begin failures++; $display("FAIL rd_no_strobe got=%0d exp=0", welow); end
    checks++;
    if (b2.cpu_rdata !== 8'hA5) begin failures++; $display("FAIL rd_data got=%0h exp=a5", b2.cpu_rdata); end
    checks++;
    if (vacks != 0) begin failures++; $display("FAIL rd_no_vid_ack got=%0d exp=0", vacks); end
  endtask

  task automatic test_cpu_write();
    int c, first, welow;
    b2.cpu_we = 1'b1; b2.cpu_addr = 21'h1FFFFF; b2.cpu_wdata = 8'h3C; b2.sram_din = 8'hEE; b2.cpu_req = 1'b1;
    c = 1; first = 0; welow = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      c++;
      if (c >= 2 && c <= 5) begin
        checks++;
        if ({b2.sram_oe, b2.sram_addr, b2.sram_dout} !== {1'b1, 21'h1FFFFF, 8'h3C}) begin
          failures++;
          $display("FAIL wr_bus cyc=%0d got oe=%0b addr=%0h dout=%0h exp 1 1fffff 3c", c, b2.sram_oe, b2.sram_addr, b2.sram_dout);
        end
        checks++;
        if (b2.sram_we_n !== ((c == 3 || c == 4) ? 1'b0 : 1'b1)) begin
          failures++;
          $display("FAIL wr_strobe cyc=%0d got=%0b exp=%0b", c, b2.sram_we_n, (c == 3 || c == 4) ? 1'b0 : 1'b1);
        end
      end
      if (b2.cpu_ack) begin
        if (first == 0) first = c;
        b2.cpu_req = 1'b0;
      end
      if (!b2.sram_we_n) welow++;
    end
    b2.cpu_we = 1'b0;
    checks++;
    if (welow != 2) begin failures++; $display("FAIL wr_strobe_len got=%0d exp=2", welow); end
    checks++;
    if (first != 5) begin failures++; $display("FAIL wr_latency got=%0d exp=5", first); end
    checks++;
    if ({b2.sram_oe, b2.sram_addr, b2.cpu_rdata} !== {1'b0, 21'h1FFFFF, 8'hA5}) begin
      failures++;
      $display("FAIL wr_idle got oe=%0b addr=%0h crd=%0h exp 0 1fffff a5", b2.sram_oe, b2.sram_addr, b2.cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    int n;
    logic pc, pv;
    seq = 4'b0000; n = 0; pc = 1'b0; pv = 1'b0;
    b2.cpu_we = 1'b0; b2.cpu_addr = 21'h00100; b2.vid_addr = 21'h00200; b2.sram_din = 8'h11;
    b2.cpu_req = 1'b1; b2.vid_req = 1'b1;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clock);
      checks++;
      if ((b2.cpu_ack & b2.vid_ack) !== 1'b0) begin
        failures++; $display("FAIL alt_overlap got cack=%0b vack=%0b exp not both", b2.cpu_ack, b2.vid_ack);
      end
      checks++;
      if (((b2.cpu_ack & pc) | (b2.vid_ack & pv)) !== 1'b0) begin
        failures++; $display("FAIL alt_width got two-cycle ack cack=%0b vack=%0b exp single", b2.cpu_ack, b2.vid_ack);
      end
      if (b2.cpu_ack || b2.vid_ack) begin
        seq = {seq[2:0], b2.vid_ack};
        n++;
      end
      pc = b2.cpu_ack; pv = b2.vid_ack;
    end
    b2.cpu_req = 1'b0; b2.vid_req = 1'b0;
    checks++;
    if (n != 4) begin failures++; $display("FAIL alt_count got=%0d exp=4", n); end
    checks++;
    if (seq !== 4'b1010) begin failures++; $display("FAIL alt_order got=%b exp=1010 (1=video)", seq); end
    checks++;
    if ({b2.cpu_rdata, b2.vid_rdata} !== {8'h11, 8'h11}) begin
      failures++; $display("FAIL alt_rdata got crd=%0h vrd=%0h exp 11 11", b2.cpu_rdata, b2.vid_rdata);
    end
    @(negedge clock);
    checks++;
    if ({b2.cpu_ack, b2.vid_ack} !== 2'b00) begin
      failures++; $display("FAIL alt_last_width got cack=%0b vack=%0b exp 0 0", b2.cpu_ack, b2.vid_ack);
    end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    logic found;
    found = 1'b0;
    b2.cpu_we = 1'b1; b2.cpu_addr = 21'h00055; b2.cpu_wdata = 8'h77; b2.cpu_req = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (b2.sram_we_n === 1'b0) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin failures++; $display("FAIL rstw_strobe_seen got=%0b exp=1", found); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({b2.sram_we_n, b2.sram_oe, b2.cpu_ack, b2.cpu_rdata, b2.vid_rdata} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL rstw_abort got we_n=%0b oe=%0b cack=%0b crd=%0h vrd=%0h exp 1 0 0 00 00",
               b2.sram_we_n, b2.sram_oe, b2.cpu_ack, b2.cpu_rdata, b2.vid_rdata);
    end
    reset = 1'b0; b2.cpu_req = 1'b0; b2.cpu_we = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clock);
      if (b2.cpu_ack) acks++;
    end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL rstw_no_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_vid_drop();
    int c, vfirst, cfirst;
    b2.vid_addr = 21'h12345; b2.cpu_addr = 21'h00777; b2.cpu_we = 1'b0; b2.sram_din = 8'h5A;
    b2.vid_req = 1'b1; b2.cpu_req = 1'b1;
    c = 1; vfirst = 0; cfirst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      c++;
      if (c == 2) begin
        b2.vid_req = 1'b0;
        checks++;
        if (b2.sram_addr !== 21'h12345) begin failures++; $display("FAIL vdrop_addr got=%0h exp=12345", b2.sram_addr); end
      end
      if (b2.vid_ack) begin
        if (vfirst == 0) vfirst = c;
        b2.sram_din = 8'h6B;
      end
      if (b2.cpu_ack) begin
        if (cfirst == 0) cfirst = c;
        b2.cpu_req = 1'b0;
      end
    end
    checks++;
    if (vfirst != 5) begin failures++; $display("FAIL vdrop_vid_ack got=%0d exp=5", vfirst); end
    checks++;
    if (cfirst != 10) begin failures++; $display("FAIL vdrop_cpu_ack got=%0d exp=10", cfirst); end
    checks++;
    if ({b2.vid_rdata, b2.cpu_rdata} !== {8'h5A, 8'h6B}) begin
      failures++; $display("FAIL vdrop_rdata got vrd=%0h crd=%0h exp 5a 6b", b2.vid_rdata, b2.cpu_rdata);
    end
  endtask

  task automatic test_sweep();
    int c, first, welow, ac;
    logic ack, wen;
    for (int k = 0; k < 2; k++) begin
      ac = (k == 0) ? 1 : 15;
      b1.cpu_we = 1'b1; b1.cpu_addr = 21'h00AAA; b1.cpu_wdata = 8'h99;
      b15.cpu_we = 1'b1; b15.cpu_addr = 21'h00AAA; b15.cpu_wdata = 8'h99;
      if (k == 0) b1.cpu_req = 1'b1;
      else        b15.cpu_req = 1'b1;
      c = 1; first = 0; welow = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        c++;
        ack = (k == 0) ? b1.cpu_ack : b15.cpu_ack;
        wen = (k == 0) ? b1.sram_we_n : b15.sram_we_n;
        if (ack) begin
          if (first == 0) first = c;
          b1.cpu_req = 1'b0; b15.cpu_req = 1'b0;
        end
        if (!wen) welow++;
      end
      checks++;
      if (welow != ac) begin failures++; $display("FAIL sweep_strobe ac=%0d got=%0d exp=%0d", ac, welow, ac); end
      checks++;
      if (first != ac + 3) begin failures++; $display("FAIL sweep_latency ac=%0d got=%0d exp=%0d", ac, first, ac + 3); end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_back_to_back();
    test_reset_mid_write();
    test_vid_drop();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
